// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared types and helpers for the interrupt front-end (intc_arbiter).
//   intc_state_e  : arbiter FSM state encoding
//   *_DFLT        : default handler vector constants
//   calc_vec()    : handler address for a maskable source index
// ---------------------------------------------------------------------------
package intc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_INT,
      REQ_NMI,
      SERVICE,
      NMI_SERVICE
   } intc_state_e;

   localparam logic [31:0] VEC_BASE_DFLT   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DFLT = 32'h0000_0008;
   localparam logic [31:0] VEC_NMI_DFLT    = 32'h0000_0080;

   function automatic logic [31:0] calc_vec(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// ---------------------------------------------------------------------------
// intc_prio_enc
// Combinational priority encoder: the lowest set request index wins.
// Ports:
//   req   in  N  request vector
//   idx   out W  index of the winning request (0 when none)
//   valid out 1  at least one request is set
// ---------------------------------------------------------------------------
module intc_prio_enc #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan from the top down so the lowest set index is the final assignment.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intc_arbiter.sv
// ---------------------------------------------------------------------------
// intc_arbiter
// Interrupt front-end for the multicycle core's Controller. Latches IRQ/NMI
// requests, masks and priority-arbitrates them, presents a stable handler
// vector until acknowledged and tracks in-service state until end-of-interrupt,
// with one level of NMI nesting over a maskable handler.
//
// Build option: define INTC_LEVEL_TRIG_EN to make the maskable sources
// level-sensitive (pending follows irq_in, ack does not clear it). NMI is
// always edge-triggered.
//
// Ports:
//   clk        in   1        core clock, rising edge
//   reset      in   1        asynchronous, active-high
//   irq_in     in   NUM_IRQ  maskable requests
//   nmi_in     in   1        non-maskable request
//   mask_wr    in   1        strobe: mask <= mask_data
//   mask_data  in   NUM_IRQ  1 = source masked
//   int_en     in   1        global maskable enable from the Controller
//   int_ack    in   1        Controller accepts the current request
//   eoi        in   1        handler finished
//   int_out    out  1        Controller INT
//   nmi_out    out  1        Controller NMI
//   intd_out   out  1        Controller INTD (handler in service)
//   vec_out    out  32       handler address while a request is up
//   src_id     out  clog2    selected maskable source
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | nothing requested or in service
// REQ_INT     | maskable request up, vector/src_id frozen
// REQ_NMI     | NMI request up
// SERVICE     | maskable handler running
// NMI_SERVICE | NMI handler running (nested flag: return to SERVICE)
// ---------------------------------------------------------------------------
module intc_arbiter
   import intc_pkg::*;
#(
   parameter int unsigned NUM_IRQ    = 8,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DFLT,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DFLT,
   parameter logic [31:0] VEC_NMI    = VEC_NMI_DFLT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_IRQ-1:0]         irq_in,
   input  logic                       nmi_in,
   input  logic                       mask_wr,
   input  logic [NUM_IRQ-1:0]         mask_data,
   input  logic                       int_en,
   input  logic                       int_ack,
   input  logic                       eoi,
   output logic                       int_out,
   output logic                       nmi_out,
   output logic                       intd_out,
   output logic [31:0]                vec_out,
   output logic [$clog2(NUM_IRQ)-1:0] src_id
);

   localparam int unsigned IDW = $clog2(NUM_IRQ);

   intc_state_e        state;
   logic               nested;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] eligible;
   logic               nmi_pend;
   logic               nmi_prev;
   logic               nmi_clr;
   logic [IDW-1:0]     win_idx;
   logic               win_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask <= '1;
      end else if (mask_wr) begin
         mask <= mask_data;
      end
   end

`ifndef INTC_LEVEL_TRIG_EN
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] ack_clr;

   always_comb begin
      ack_clr = '0;
      if (state == REQ_INT && int_ack) begin
         ack_clr[src_id] = 1'b1;
      end
   end

   // A fresh edge overrides a simultaneous ack clear of the same source.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_prev <= '1;
         pending  <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~ack_clr) | (irq_in & ~irq_prev);
      end
   end
`else
   assign pending = irq_in;
`endif

   assign nmi_clr = (state == REQ_NMI) && int_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nmi_prev <= 1'b1;
         nmi_pend <= 1'b0;
      end else begin
         nmi_prev <= nmi_in;
         nmi_pend <= (nmi_pend & ~nmi_clr) | (nmi_in & ~nmi_prev);
      end
   end

   assign eligible = pending & ~mask & {NUM_IRQ{int_en}};

   intc_prio_enc #(
      .N (NUM_IRQ),
      .W (IDW)
   ) u_prio_enc (
      .req   (eligible),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         nested   <= 1'b0;
         int_out  <= 1'b0;
         nmi_out  <= 1'b0;
         intd_out <= 1'b0;
         vec_out  <= '0;
         src_id   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (nmi_pend) begin
                  state   <= REQ_NMI;
                  nmi_out <= 1'b1;
                  vec_out <= VEC_NMI;
                  nested  <= 1'b0;
               end else if (win_valid) begin
                  state   <= REQ_INT;
                  int_out <= 1'b1;
                  src_id  <= win_idx;
                  vec_out <= calc_vec(VEC_BASE, VEC_STRIDE, 32'(win_idx));
               end
            end
            REQ_INT: begin
               if (int_ack) begin
                  state    <= SERVICE;
                  int_out  <= 1'b0;
                  intd_out <= 1'b1;
                  vec_out  <= '0;
               end else if (nmi_pend) begin
                  // Preempted source keeps its pending bit and is re-arbitrated later.
                  state   <= REQ_NMI;
                  int_out <= 1'b0;
                  nmi_out <= 1'b1;
                  vec_out <= VEC_NMI;
                  nested  <= 1'b0;
               end
            end
            REQ_NMI: begin
               if (int_ack) begin
                  state    <= NMI_SERVICE;
                  nmi_out  <= 1'b0;
                  intd_out <= 1'b1;
                  vec_out  <= '0;
               end
            end
            SERVICE: begin
               if (eoi) begin
                  state    <= IDLE;
                  intd_out <= 1'b0;
                  src_id   <= '0;
               end else if (nmi_pend) begin
                  // intd_out stays high: the maskable handler is still in service.
                  state   <= REQ_NMI;
                  nmi_out <= 1'b1;
                  vec_out <= VEC_NMI;
                  nested  <= 1'b1;
               end
            end
            NMI_SERVICE: begin
               if (eoi) begin
                  nested <= 1'b0;
                  if (nested) begin
                     state <= SERVICE;
                  end else begin
                     state    <= IDLE;
                     intd_out <= 1'b0;
                     src_id   <= '0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               nested   <= 1'b0;
               int_out  <= 1'b0;
               nmi_out  <= 1'b0;
               intd_out <= 1'b0;
               vec_out  <= '0;
               src_id   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_intc_arbiter
// Self-checking bench for intc_arbiter (default edge-triggered build).
// ---------------------------------------------------------------------------
module tb_intc_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  irq_in;
   logic        nmi_in;
   logic        mask_wr;
   logic [7:0]  mask_data;
   logic        int_en;
   logic        int_ack;
   logic        eoi;
   logic        int_out;
   logic        nmi_out;
   logic        intd_out;
   logic [31:0] vec_out;
   logic [2:0]  src_id;

   int n_checks = 0;
   int n_fail   = 0;

   bit [7:0] model_pend = '0;
   bit [7:0] cur_mask   = '1;

   intc_arbiter #(.NUM_IRQ(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .nmi_in    (nmi_in),
      .mask_wr   (mask_wr),
      .mask_data (mask_data),
      .int_en    (int_en),
      .int_ack   (int_ack),
      .eoi       (eoi),
      .int_out   (int_out),
      .nmi_out   (nmi_out),
      .intd_out  (intd_out),
      .vec_out   (vec_out),
      .src_id    (src_id)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] vec_of(input int idx);
      return 32'h100 + 32'(idx) * 32'h8;
   endfunction

   function automatic int winner(input bit [7:0] p, input bit [7:0] m);
      for (int i = 0; i < 8; i++) begin
         if (p[i] && !m[i]) return i;
      end
      return -1;
   endfunction

   task automatic wait_int(input int max, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < max; c++) begin
         if (int_out === 1'b1) begin
            seen = 1'b1;
            return;
         end
         step();
      end
      seen = (int_out === 1'b1);
   endtask

   task automatic wait_nmi(input int max, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < max; c++) begin
         if (nmi_out === 1'b1) begin
            seen = 1'b1;
            return;
         end
         step();
      end
      seen = (nmi_out === 1'b1);
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
   endtask

   task automatic pulse_irq(input logic [7:0] pat);
      irq_in = pat;
      step();
      irq_in = '0;
   endtask

   task automatic pulse_nmi();
      nmi_in = 1'b1;
      step();
      nmi_in = 1'b0;
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_wr   = 1'b1;
      mask_data = m;
      step();
      mask_wr   = 1'b0;
      cur_mask  = m;
   endtask

   task automatic test_reset();
      bit seen;
      reset = 1'b1; irq_in = 8'h40; nmi_in = 1'b1; mask_wr = 0; mask_data = 0;
      int_en = 1'b1; int_ack = 0; eoi = 0;
      #1;
      n_checks++;
      if ({int_out, nmi_out, intd_out, vec_out, src_id} !== '0)
         $display("FAIL reset_outputs: got %b/%b/%b %h %0d required all zero",
                  int_out, nmi_out, intd_out, vec_out, src_id);
      step(); step();
      reset = 1'b0;
      repeat (4) step();
      n_checks++;
      if (int_out !== 1'b0 || nmi_out !== 1'b0) begin
         n_fail++;
         $display("FAIL held_lines: int_out=%b nmi_out=%b required 0/0", int_out, nmi_out);
      end
      // New edge on irq[2] is latched but masked by the reset mask value.
      irq_in[2] = 1'b1;
      step();
      irq_in[2] = 1'b0;
      repeat (3) step();
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mask_ones: int_out=%b required 0", int_out);
      end
      write_mask(8'h00);
      wait_int(4, seen);
      n_checks++;
      if (!seen || vec_out !== vec_of(2) || src_id !== 3'd2) begin
         n_fail++;
         $display("FAIL reset_unmask: seen=%b vec=%h src=%0d required 1 %h 2",
                  seen, vec_out, src_id, vec_of(2));
      end
      pulse_ack();
      pulse_eoi();
      repeat (3) step();
      n_checks++;
      if (int_out !== 1'b0 || intd_out !== 1'b0) begin
         n_fail++;
         $display("FAIL held_irq_quiet: int_out=%b intd=%b required 0/0", int_out, intd_out);
      end
      irq_in = '0;
      nmi_in = 1'b0;
      step(); step();
   endtask

   task automatic test_single();
      irq_in[3] = 1'b1;
      step();
      irq_in[3] = 1'b0;
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency_early: int_out=%b required 0", int_out);
      end
      step();
      n_checks++;
      if (int_out !== 1'b1 || vec_out !== 32'h118 || src_id !== 3'd3) begin
         n_fail++;
         $display("FAIL single_req: int_out=%b vec=%h src=%0d required 1 00000118 3",
                  int_out, vec_out, src_id);
      end
      pulse_ack();
      n_checks++;
      if (intd_out !== 1'b1 || int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: intd=%b int_out=%b required 1/0", intd_out, int_out);
      end
      pulse_eoi();
      n_checks++;
      if ({int_out, nmi_out, intd_out, vec_out, src_id} !== '0) begin
         n_fail++;
         $display("FAIL single_eoi: %b/%b/%b %h %0d required all zero",
                  int_out, nmi_out, intd_out, vec_out, src_id);
      end
   endtask

   task automatic test_simultaneous();
      bit seen;
      pulse_irq(8'h24);
      wait_int(4, seen);
      n_checks++;
      if (!seen || vec_out !== 32'h110) begin
         n_fail++;
         $display("FAIL simul_first: seen=%b vec=%h required 1 00000110", seen, vec_out);
      end
      pulse_ack();
      pulse_eoi();
      wait_int(4, seen);
      n_checks++;
      if (!seen || vec_out !== 32'h128 || src_id !== 3'd5) begin
         n_fail++;
         $display("FAIL simul_second: seen=%b vec=%h src=%0d required 1 00000128 5",
                  seen, vec_out, src_id);
      end
      pulse_ack();
      pulse_eoi();
   endtask

   task automatic test_mask();
      write_mask(8'h08);
      pulse_irq(8'h08);
      repeat (3) step();
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL masked_src: int_out=%b required 0", int_out);
      end
      write_mask(8'h00);
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL unmask_early: int_out=%b required 0", int_out);
      end
      step();
      n_checks++;
      if (int_out !== 1'b1 || vec_out !== 32'h118) begin
         n_fail++;
         $display("FAIL unmask_req: int_out=%b vec=%h required 1 00000118", int_out, vec_out);
      end
      pulse_ack();
      pulse_eoi();
   endtask

   task automatic test_ignored();
      bit seen;
      pulse_ack();
      pulse_eoi();
      n_checks++;
      if ({int_out, nmi_out, intd_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL ignored_idle: %b/%b/%b required 000", int_out, nmi_out, intd_out);
      end
      pulse_irq(8'h80);
      wait_int(4, seen);
      pulse_ack();
      pulse_ack();
      step();
      n_checks++;
      if (intd_out !== 1'b1 || int_out !== 1'b0 || nmi_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ignored_ack_service: intd=%b int=%b nmi=%b required 1/0/0",
                  intd_out, int_out, nmi_out);
      end
      pulse_eoi();
   endtask

   task automatic test_nmi_nesting();
      bit seen;
      pulse_irq(8'h02);
      wait_int(4, seen);
      pulse_ack();
      pulse_nmi();
      wait_nmi(4, seen);
      n_checks++;
      if (!seen || vec_out !== 32'h80 || int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL nest_nmi_req: seen=%b vec=%h int=%b required 1 00000080 0",
                  seen, vec_out, int_out);
      end
      pulse_ack();
      n_checks++;
      if (intd_out !== 1'b1 || nmi_out !== 1'b0) begin
         n_fail++;
         $display("FAIL nest_nmi_ack: intd=%b nmi=%b required 1/0", intd_out, nmi_out);
      end
      pulse_eoi();
      step();
      n_checks++;
      if (intd_out !== 1'b1 || int_out !== 1'b0 || nmi_out !== 1'b0) begin
         n_fail++;
         $display("FAIL nest_return: intd=%b int=%b nmi=%b required 1/0/0",
                  intd_out, int_out, nmi_out);
      end
      pulse_eoi();
      n_checks++;
      if ({int_out, nmi_out, intd_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL nest_final: %b/%b/%b required 000", int_out, nmi_out, intd_out);
      end
   endtask

   task automatic test_nmi_preempt();
      bit seen;
      pulse_irq(8'h10);
      wait_int(4, seen);
      pulse_nmi();
      step();
      n_checks++;
      if (int_out !== 1'b0 || nmi_out !== 1'b1 || vec_out !== 32'h80) begin
         n_fail++;
         $display("FAIL preempt: int=%b nmi=%b vec=%h required 0 1 00000080",
                  int_out, nmi_out, vec_out);
      end
      pulse_ack();
      pulse_eoi();
      n_checks++;
      if (intd_out !== 1'b0) begin
         n_fail++;
         $display("FAIL preempt_eoi: intd=%b required 0", intd_out);
      end
      wait_int(4, seen);
      n_checks++;
      if (!seen || vec_out !== vec_of(4) || src_id !== 3'd4) begin
         n_fail++;
         $display("FAIL preempt_resume: seen=%b vec=%h src=%0d required 1 %h 4",
                  seen, vec_out, src_id, vec_of(4));
      end
      pulse_ack();
      pulse_eoi();
   endtask

   task automatic test_random();
      bit seen;
      int w;
      logic [7:0] m;
      logic [7:0] pat;
      for (int it = 0; it < 25; it++) begin
         m   = (it == 24) ? 8'h00 : 8'($urandom);
         pat = 8'($urandom);
         int_en = 1'b0;
         write_mask(m);
         pulse_irq(pat);
         model_pend |= pat;
         step(); step();
         n_checks++;
         if (int_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_int_en_gate: it=%0d int_out=%b required 0", it, int_out);
         end
         int_en = 1'b1;
         for (int g = 0; g < 9; g++) begin
            w = winner(model_pend, cur_mask);
            if (w < 0) begin
               repeat (3) step();
               n_checks++;
               if (int_out !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rnd_quiet: it=%0d int_out=%b required 0", it, int_out);
               end
               break;
            end
            wait_int(6, seen);
            n_checks++;
            if (!seen || src_id !== 3'(w) || vec_out !== vec_of(w)) begin
               n_fail++;
               $display("FAIL rnd_grant: it=%0d seen=%b src=%0d vec=%h required 1 %0d %h",
                        it, seen, src_id, vec_out, w, vec_of(w));
               if (!seen) break;
            end
            pulse_ack();
            model_pend[w] = 1'b0;
            n_checks++;
            if (intd_out !== 1'b1 || int_out !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_ack: it=%0d intd=%b int=%b required 1/0", it, intd_out, int_out);
            end
            pulse_eoi();
         end
      end
   endtask

   task automatic test_reset_midreq();
      bit seen;
      pulse_irq(8'h80);
      wait_int(4, seen);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({int_out, nmi_out, intd_out, vec_out, src_id} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: %b/%b/%b %h %0d required all zero",
                  int_out, nmi_out, intd_out, vec_out, src_id);
      end
      step();
      reset = 1'b0;
      step();
      pulse_irq(8'h01);
      repeat (3) step();
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_mask: int_out=%b required 0", int_out);
      end
      write_mask(8'h00);
      wait_int(4, seen);
      n_checks++;
      if (!seen || vec_out !== 32'h100) begin
         n_fail++;
         $display("FAIL reset_mid_unmask: seen=%b vec=%h required 1 00000100", seen, vec_out);
      end
      pulse_ack();
      pulse_eoi();
      repeat (3) step();
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_cleared: int_out=%b required 0", int_out);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_mask();
      test_ignored();
      test_nmi_nesting();
      test_nmi_preempt();
      test_random();
      test_reset_midreq();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
